rr_wrr_arb: RTL and testbench

Weighted round-robin arbiter, the parametrised successor to `rr_top`. It grants one of `REQCNT` requesters per burst, where a burst is up to `weight` accepted beats. A valid/ready grant handshake lets the downstream consumer apply backpressure. A built-in saturating max-wait monitor replaces the bench-side statistics logic.

---
 rtl/rr_wrr_arb.sv | 181 ++++++++++++++++++
 tb/tb_rr_wrr_arb.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_wrr_arb.sv
// rr_wrr_arb -- weighted round-robin arbiter with valid/ready grant handshake
// and a saturating max-wait monitor.
//
// A requester wins a burst of up to max(weight,1) accepted beats. Selection
// starts one past the last granted index and wraps, so requester 0 has top
// priority right after reset. A burst ends early when the grantee drops its
// request at a handshake; re-arbitration then happens in the same cycle so
// the grant stream has no bubble.
//
// Ports:
//   clk_i          clock
//   rst_n_i        asynchronous active-low reset
//   req_i          request bits, one per requester
//   weight_i       packed weights, requester i at [i*WEIGHT_W +: WEIGHT_W]
//   gnt_rdy_i      consumer accepts the current grant beat
//   gnt_val_o      grant valid
//   gnt_num_o      index of the granted requester
//   gnt_last_o     current beat uses the last unit of burst credit
//   max_wait_o     largest per-requester wait seen since reset/clear
//   max_wait_clr_i synchronous clear of max_wait_o
module rr_wrr_arb #(
  parameter int REQCNT   = 4,
  parameter int WEIGHT_W = 4,
  parameter int WAIT_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [REQCNT-1:0]             req_i,
  input  logic [REQCNT*WEIGHT_W-1:0]    weight_i,
  input  logic                          gnt_rdy_i,
  output logic                          gnt_val_o,
  output logic [$clog2(REQCNT)-1:0]     gnt_num_o,
  output logic                          gnt_last_o,
  output logic [WAIT_W-1:0]             max_wait_o,
  input  logic                          max_wait_clr_i
);

  localparam int IDX_W = $clog2(REQCNT);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;
  logic                gnt_val_q;
  logic [IDX_W-1:0]    gnt_num_q;
  logic                gnt_last_q;
  logic [WAIT_W-1:0]   wait_q [REQCNT];
  logic [WAIT_W-1:0]   wait_d [REQCNT];
  logic [WAIT_W-1:0]   max_q, max_d;

  logic [WEIGHT_W-1:0] w_arr [REQCNT];
  logic [IDX_W-1:0]    pick_idle;
  logic [IDX_W-1:0]    pick_end;
  logic                hs;

  // First requesting index after 'last', wrapping; returns 'last' when
  // nothing requests (callers only use the result when |req is true).
  function automatic logic [IDX_W-1:0] pick(input logic [REQCNT-1:0] req,
                                            input logic [IDX_W-1:0]  last);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= REQCNT; k++) begin
      idx = IDX_W'((int'(last) + k) % REQCNT);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // A zero weight still earns one beat per burst.
  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == '1) ? v : v + WAIT_W'(1);
  endfunction

  function automatic logic [WAIT_W-1:0] umax(input logic [WAIT_W-1:0] a,
                                             input logic [WAIT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  for (genvar g = 0; g < REQCNT; g++) begin : g_warr
    assign w_arr[g] = weight_i[g*WEIGHT_W +: WEIGHT_W];
  end

  assign hs        = gnt_val_q && gnt_rdy_i;
  assign pick_idle = pick(req_i, ptr_q);
  // At a burst end the pointer moves to cur, so search from cur.
  assign pick_end  = pick(req_i, cur_q);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          cur_d    = pick_idle;
          credit_d = eff_weight(w_arr[pick_idle]);
          state_d  = GRANT;
        end
      end
      GRANT: begin
        if (hs) begin
          if ((credit_q > WEIGHT_W'(1)) && req_i[cur_q]) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end else begin
            ptr_d = cur_q;
            if (|req_i) begin
              cur_d    = pick_end;
              credit_d = eff_weight(w_arr[pick_end]);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Wait counters see the grant currently presented on the outputs.
  always_comb begin
    max_d = max_q;
    for (int i = 0; i < REQCNT; i++) begin
      if (req_i[i] && !(gnt_val_q && (gnt_num_q == IDX_W'(i))))
        wait_d[i] = sat_inc(wait_q[i]);
      else
        wait_d[i] = '0;
      max_d = umax(max_d, wait_d[i]);
    end
    if (max_wait_clr_i)
      max_d = '0;
  end

  // Register stage: arbitration state, grant outputs and wait monitor.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      ptr_q      <= IDX_W'(REQCNT - 1);
      cur_q      <= '0;
      credit_q   <= '0;
      gnt_val_q  <= 1'b0;
      gnt_num_q  <= '0;
      gnt_last_q <= 1'b0;
      max_q      <= '0;
      for (int i = 0; i < REQCNT; i++)
        wait_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cur_q      <= cur_d;
      credit_q   <= credit_d;
      gnt_val_q  <= (state_d == GRANT);
      gnt_num_q  <= cur_d;
      gnt_last_q <= (state_d == GRANT) && (credit_d == WEIGHT_W'(1));
      max_q      <= max_d;
      for (int i = 0; i < REQCNT; i++)
        wait_q[i] <= wait_d[i];
    end
  end

  assign gnt_val_o  = gnt_val_q;
  assign gnt_num_o  = gnt_num_q;
  assign gnt_last_o = gnt_last_q;
  assign max_wait_o = max_q;

endmodule

// File: tb/tb_rr_wrr_arb.sv
// Bench for rr_wrr_arb: table of steady-state grant patterns checked through
// a scoreboard queue, plus hand sequences for reset, backpressure, early
// release and wait-counter saturation (second instance with WAIT_W=4).
module tb_rr_wrr_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] weight;
  logic        rdy;
  logic        clr;

  logic        gnt_val,  gnt_last;
  logic [1:0]  gnt_num;
  logic [15:0] max_wait;
  logic        gnt_val2, gnt_last2;
  logic [1:0]  gnt_num2;
  logic [3:0]  max_wait2;

  int total = 0;
  int bad   = 0;

  rr_wrr_arb #(.REQCNT(4), .WEIGHT_W(4), .WAIT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .weight_i(weight),
    .gnt_rdy_i(rdy), .gnt_val_o(gnt_val), .gnt_num_o(gnt_num),
    .gnt_last_o(gnt_last), .max_wait_o(max_wait), .max_wait_clr_i(clr)
  );

  rr_wrr_arb #(.REQCNT(4), .WEIGHT_W(4), .WAIT_W(4)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .weight_i(weight),
    .gnt_rdy_i(rdy), .gnt_val_o(gnt_val2), .gnt_num_o(gnt_num2),
    .gnt_last_o(gnt_last2), .max_wait_o(max_wait2), .max_wait_clr_i(clr)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0] num;
    logic       last;
  } exp_t;

  typedef struct packed {
    logic [3:0]      req;
    logic [15:0]     w;
    logic [3:0]      period;
    logic [7:0][1:0] num;   // element 0 is the first beat
    logic [7:0]      last;  // bit 0 is the first beat
    logic [15:0]     maxw;  // steady-state max wait
  } vec_t;

  vec_t vt [5];
  exp_t sb [$];

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = '0;
    rdy    = 1'b0;
    clr    = 1'b0;
    weight = '0;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   beats;
    int   cyc;
    int   seen;

    vt[0] = '{req: 4'b1111, w: 16'h1111, period: 4'd4,
              num: {2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
              last: 8'b0000_1111, maxw: 16'd3};
    vt[1] = '{req: 4'b1111, w: 16'h0213, period: 4'd7,
              num: {2'd0, 2'd3, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0},
              last: 8'b0110_1100, maxw: 16'd6};
    vt[2] = '{req: 4'b0101, w: 16'h2222, period: 4'd4,
              num: {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd0, 2'd0},
              last: 8'b0000_1010, maxw: 16'd2};
    vt[3] = '{req: 4'b1000, w: 16'h2000, period: 4'd2,
              num: {2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3},
              last: 8'b0000_0010, maxw: 16'd0};
    vt[4] = '{req: 4'b0110, w: 16'h0310, period: 4'd4,
              num: {2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd1},
              last: 8'b0000_1001, maxw: 16'd3};

    rst_n = 1'b0; req = '0; weight = '0; rdy = 1'b0; clr = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_val",  gnt_val,  0);
    check("rst_num",  gnt_num,  0);
    check("rst_last", gnt_last, 0);
    check("rst_max",  max_wait, 0);
    check("rst_max2", max_wait2, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req_val", gnt_val, 0);

    // Table-driven steady-state patterns
    for (int v = 0; v < 5; v++) begin
      do_reset();
      weight = vt[v].w;
      req    = vt[v].req;
      rdy    = 1'b1;
      sb.delete();
      for (int b = 0; b < 16; b++) begin
        int idx;
        idx    = b % int'(vt[v].period);
        e.num  = vt[v].num[idx];
        e.last = vt[v].last[idx];
        sb.push_back(e);
      end
      beats = 0;
      cyc   = 0;
      while (sb.size() > 0 && cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (beats > 0) check($sformatf("v%0d_no_bubble", v), gnt_val, 1);
        if (gnt_val) begin
          e = sb.pop_front();
          check($sformatf("v%0d_b%0d_num", v, beats), gnt_num, e.num);
          check($sformatf("v%0d_b%0d_last", v, beats), gnt_last, e.last);
          beats++;
          // clear once every requester has been served, leaving steady state
          clr = (beats == 9);
        end
      end
      check($sformatf("v%0d_pending", v), sb.size(), 0);
      check($sformatf("v%0d_max_wait", v), max_wait, vt[v].maxw);
      clr = 1'b0;
    end

    // Asynchronous reset in the middle of a burst
    do_reset();
    weight = 16'h3333;
    req    = 4'b1100;
    rdy    = 1'b0;
    repeat (3) @(negedge clk);
    check("ar_pre_num", gnt_num, 2);
    check("ar_pre_max", max_wait, 3);
    #2 rst_n = 1'b0;
    #1;
    check("ar_val",  gnt_val,  0);
    check("ar_num",  gnt_num,  0);
    check("ar_last", gnt_last, 0);
    check("ar_max",  max_wait, 0);
    @(negedge clk);
    req   = 4'b1111;
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_first_val", gnt_val, 1);
    check("ar_first_num", gnt_num, 0);

    // Backpressure while requester 2 is granted, with its request dropped
    do_reset();
    weight = 16'h1111;
    req    = 4'b1111;
    rdy    = 1'b1;
    seen   = 0;
    cyc    = 0;
    while (seen < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gnt_val && gnt_num == 2'd2) seen++;
    end
    check("bp_reach", seen, 2);
    rdy = 1'b0;
    clr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        clr = 1'b0;
        req = 4'b1011;
      end
      check($sformatf("bp_c%0d_val", k), gnt_val, 1);
      check($sformatf("bp_c%0d_num", k), gnt_num, 2);
      check($sformatf("bp_c%0d_last", k), gnt_last, 1);
    end
    check("bp_max_wait", max_wait, 7);
    rdy = 1'b1;
    @(negedge clk);
    check("bp_next_num", gnt_num, 3);

    // Early release: requester 0 drops its request at the 2nd handshake
    do_reset();
    weight = 16'h0014;
    req    = 4'b0011;
    rdy    = 1'b1;
    sb.delete();
    e = '{num: 2'd0, last: 1'b0}; sb.push_back(e);
    e = '{num: 2'd0, last: 1'b0}; sb.push_back(e);
    e = '{num: 2'd1, last: 1'b1}; sb.push_back(e);
    e = '{num: 2'd0, last: 1'b0}; sb.push_back(e);
    e = '{num: 2'd0, last: 1'b0}; sb.push_back(e);
    beats = 0;
    cyc   = 0;
    while (sb.size() > 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gnt_val) begin
        e = sb.pop_front();
        check($sformatf("er_b%0d_num", beats), gnt_num, e.num);
        check($sformatf("er_b%0d_last", beats), gnt_last, e.last);
        beats++;
        if (beats == 2) req = 4'b0010;
        if (beats == 3) req = 4'b0011;
      end
    end
    check("er_pending", sb.size(), 0);

    // Saturation of the wait monitor and its clear
    do_reset();
    weight = 16'h1111;
    req    = 4'b1001;
    rdy    = 1'b0;
    repeat (20) @(negedge clk);
    check("sat_val2",  gnt_val2, 1);
    check("sat_num2",  gnt_num2, 0);
    check("sat_max2",  max_wait2, 15);
    check("sat_max16", max_wait, 20);
    repeat (5) @(negedge clk);
    check("sat_hold_max2",  max_wait2, 15);
    check("sat_hold_max16", max_wait, 25);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_max2",  max_wait2, 0);
    check("clr_max16", max_wait, 0);
    @(negedge clk);
    check("post_clr_max2",  max_wait2, 15);
    check("post_clr_max16", max_wait, 27);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
